// File: rtl/move_scheduler.sv
// Snake step scheduler: paces step requests from the BCD score and buffers
// direction keys in a 2-entry FIFO that rejects same-heading and reversing turns.
module move_scheduler #(
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned PERIOD_DEC  = 2_000_000,
  parameter int unsigned MIN_PERIOD  = 5_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  status,
  input  logic [15:0] point,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        step_ack,
  output logic        step_req,
  output logic [1:0]  step_dir,
  output logic [1:0]  cur_dir,
  output logic [3:0]  level,
  output logic [1:0]  q_count
);

  localparam logic [1:0] ST_RESTART = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b10;
  localparam logic [1:0] DIR_RIGHT  = 2'b11;

  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0] DEC_C  = CNT_W'(PERIOD_DEC);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, COUNT, WAIT} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] dec, diff, period, period_m1;
  logic             step_req_d;
  logic [1:0]       step_dir_d, cur_dir_d, q_count_d;
  logic [3:0]       level_d, level_in;
  logic [1:0]       fifo0, fifo1, fifo0_d, fifo1_d;
  logic [1:0]       key_dir, ref_dir, count_pop;
  logic             key_any, pop, accept;
  logic             unused_point;

  assign unused_point = ^{point[15:8], point[3:0]};

  // Step period from the latched level, floored at MIN and guarded against underflow
  always_comb begin
    dec       = CNT_W'(level) * DEC_C;
    diff      = BASE_C - dec;
    period    = (dec >= BASE_C || diff < MIN_C) ? MIN_C : diff;
    period_m1 = period - CNT_W'(1);
    level_in  = (point[7:4] > 4'd9) ? 4'd9 : point[7:4];
  end

  // Next-state, step engine and direction FIFO
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    step_req_d = step_req;
    step_dir_d = step_dir;
    cur_dir_d  = cur_dir;
    level_d    = level;
    q_count_d  = q_count;
    fifo0_d    = fifo0;
    fifo1_d    = fifo1;
    pop        = 1'b0;
    accept     = 1'b0;
    count_pop  = q_count;
    key_any    = key_up | key_down | key_left | key_right;
    if (key_up)        key_dir = 2'b00;
    else if (key_down) key_dir = 2'b01;
    else if (key_left) key_dir = 2'b10;
    else               key_dir = 2'b11;
    // Tail of the queue (or the head being popped, or the heading) is the turn reference
    if (q_count == 2'd0)      ref_dir = cur_dir;
    else if (q_count == 2'd2) ref_dir = fifo1;
    else                      ref_dir = fifo0;

    if (status != ST_PLAY) begin
      state_d    = IDLE;
      cnt_d      = '0;
      step_req_d = 1'b0;
      q_count_d  = 2'd0;
      if (status == ST_RESTART) begin
        cur_dir_d  = DIR_RIGHT;
        step_dir_d = DIR_RIGHT;
        level_d    = 4'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = '0;
          level_d = level_in;
        end
        COUNT: begin
          if (cnt == period_m1) begin
            pop        = (q_count != 2'd0);
            cur_dir_d  = pop ? fifo0 : cur_dir;
            step_dir_d = pop ? fifo0 : cur_dir;
            step_req_d = 1'b1;
            state_d    = WAIT;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (step_ack) begin
            step_req_d = 1'b0;
            cnt_d      = '0;
            level_d    = level_in;
            state_d    = COUNT;
          end
        end
        default: state_d = IDLE;
      endcase

      count_pop = q_count - 2'(pop);
      if (pop) fifo0_d = fifo1;
      accept = key_any && (key_dir != ref_dir) && (key_dir != (ref_dir ^ 2'b01))
               && (count_pop != 2'd2);
      if (accept) begin
        if (count_pop == 2'd0) fifo0_d = key_dir;
        else                   fifo1_d = key_dir;
      end
      q_count_d = count_pop + 2'(accept);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      step_req <= 1'b0;
      step_dir <= DIR_RIGHT;
      cur_dir  <= DIR_RIGHT;
      level    <= 4'd0;
      q_count  <= 2'd0;
      fifo0    <= 2'd0;
      fifo1    <= 2'd0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      step_req <= step_req_d;
      step_dir <= step_dir_d;
      cur_dir  <= cur_dir_d;
      level    <= level_d;
      q_count  <= q_count_d;
      fifo0    <= fifo0_d;
      fifo1    <= fifo1_d;
    end
  end

endmodule
